complex_counter_arbiter: RTL and testbench
==========================================

COMPLEX_COUNTER_ARBITER -- requirements
Module: complex_counter_arbiter

Interface
REQ-001 The block SHALL have the parameter NSTEP_MAX, default 8, meaning the step limit per granted job before an error is flagged.
REQ-002 The block SHALL have port CLOCK  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nReset  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port REQ  input  2  per-requester job request, level, held until ACK.
REQ-005 The block SHALL have port MODE_IN  input  2  per-requester mode bit; MODE_IN[i] belongs to REQ[i].
REQ-006 The block SHALL have port TGT0, TGT1  input  3 each  per-requester target COUNT value.
REQ-007 The block SHALL have port COUNT  input  3  current value of the shared 3-bit mode-dependent counter.
REQ-008 The block SHALL have port M  output  1  mode driven to the shared counter.
REQ-009 The block SHALL have port STEP  output  1  counter advance enable; the counter moves one state on each rising CLOCK edge with STEP=1.
REQ-010 The block SHALL have port GNT  output  2  one-hot owner of the counter; all-zero when idle.
REQ-011 The block SHALL have port ACK  output  2  one-cycle job-complete pulse to the owner.
REQ-012 The block SHALL have port ERR  output  1  valid with ACK; 1 = step limit reached before target.
REQ-013 The block SHALL have port BUSY  output  1  1 whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and FIN, encoded in 2 bits; the unused code SHALL return to IDLE.
REQ-015 In IDLE with REQ != 0, the block SHALL select the owner as follows:
- if only one REQ bit is set, select that requester;
- if both bits are set, select the requester named by the 1-bit round-robin pointer PTR.
REQ-016 On selecting an owner, the block SHALL latch the owner's MODE_IN and TGT in the same edge and enter RUN on the next edge.
REQ-017 REQ, MODE_IN and TGT changes after latching SHALL NOT affect the running job.
REQ-018 GNT[owner] SHALL be 1 throughout RUN and FIN, and 0 otherwise.
REQ-019 In RUN, M SHALL equal the latched mode.
REQ-020 In RUN, STEP SHALL be driven combinationally:
- STEP = 0 when COUNT == latched target;
- STEP = 1 otherwise.
REQ-021 In RUN, the step counter SHALL be 4 bits, cleared on grant, and incremented on each edge with STEP=1.
REQ-022 The block SHALL leave RUN for FIN when either of the following holds:
- COUNT == target, giving ERR=0;
- the step counter reaches NSTEP_MAX, giving ERR=1, latched.
REQ-023 A target already equal to COUNT at RUN entry SHALL give zero steps: RUN lasts 1 cycle with STEP=0, then FIN.
REQ-024 FIN SHALL last exactly 1 cycle, during which:
- ACK[owner] = 1;
- ERR is valid;
- STEP = 0.
REQ-025 On leaving FIN, PTR SHALL point to the non-owner, and the state SHALL return to IDLE.
REQ-026 The minimum gap between jobs SHALL be one IDLE cycle.
REQ-027 Outside RUN, STEP SHALL be 0 and M SHALL be 0.
REQ-028 ACK and ERR SHALL be 0 outside FIN.
REQ-029 A REQ withdrawn during RUN SHALL NOT abort the job; the job completes and ACK still pulses.
REQ-030 A requester still asserting REQ after its own ACK SHALL be treated as a new job.

Reset
REQ-031 With nReset=0, the block SHALL immediately, independent of CLOCK, set:
- state to IDLE;
- PTR to 0;
- step counter, latched mode and latched target to 0;
- GNT, ACK, ERR, STEP, M and BUSY to 0.
REQ-032 A reset asserted mid-RUN SHALL abandon the job with no ACK; the requester re-requests after reset.
REQ-033 The first edge after nReset rises SHALL be an ordinary IDLE evaluation.

Verification
REQ-034 The bench SHALL cover at minimum these directed scenarios:
- Counter at 0; REQ=01, MODE_IN[0]=0, TGT0=3 -> GNT=01, STEP high 3 cycles, COUNT ends 3, ACK=01 with ERR=0, PTR=1.
- Counter at 0; REQ=10, MODE_IN[1]=1, TGT1=6 -> M=1, 4 steps (0->1->3->2->6), ACK=10, ERR=0.
- REQ=11 held continuously, PTR=0 -> service order 0,1,0,1; each ACK followed by one IDLE cycle before the next GNT.
- TGT0 equal to current COUNT -> one RUN cycle with STEP=0, ACK next cycle, counter unchanged.
- Counter model stuck (ignores STEP), TGT0 != COUNT -> 8 STEP cycles, then ACK with ERR=1.
- nReset pulsed low mid-RUN -> all outputs 0 asynchronously, no ACK, PTR=0, next REQ=11 grants requester 0.

Source files
------------

// File: rtl/complex_counter_arbiter.sv
// complex_counter_arbiter: grants a shared 3-bit mode-dependent counter to one of
// two requesters, steps it until it reaches the owner's target (or a step limit
// expires), then pulses ACK/ERR back to the owner and rotates priority.
module complex_counter_arbiter #(
  parameter int NSTEP_MAX = 8
) (
  input  logic       CLOCK,
  input  logic       nReset,
  input  logic [1:0] REQ,
  input  logic [1:0] MODE_IN,
  input  logic [2:0] TGT0,
  input  logic [2:0] TGT1,
  input  logic [2:0] COUNT,
  output logic       M,
  output logic       STEP,
  output logic [1:0] GNT,
  output logic [1:0] ACK,
  output logic       ERR,
  output logic       BUSY
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  localparam logic [3:0] STEP_LIMIT = 4'(NSTEP_MAX);

  logic [1:0] state_r;
  logic [1:0] state_s;
  logic       ptr_r;
  logic       owner_r;
  logic       mode_r;
  logic [2:0] tgt_r;
  logic [3:0] step_cnt_r;
  logic       err_r;

  logic       sel_s;
  logic       hit_s;
  logic       limit_s;
  logic [1:0] owner_oh_s;

  // Owner selection, target hit and step-limit detection
  always_comb begin
    if (REQ == 2'b11) begin
      sel_s = ptr_r;
    end else begin
      sel_s = REQ[1];
    end
    hit_s      = (COUNT == tgt_r);
    limit_s    = ((step_cnt_r + 4'd1) == STEP_LIMIT);
    owner_oh_s = owner_r ? 2'b10 : 2'b01;
  end

  // State register
  always_ff @(posedge CLOCK or negedge nReset) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hit_s || limit_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Job context: latched on grant, step counting in RUN, pointer rotation in FIN
  always_ff @(posedge CLOCK or negedge nReset) begin
    if (!nReset) begin
      ptr_r      <= 1'b0;
      owner_r    <= 1'b0;
      mode_r     <= 1'b0;
      tgt_r      <= 3'd0;
      step_cnt_r <= 4'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (REQ != 2'b00) begin
            owner_r    <= sel_s;
            mode_r     <= MODE_IN[sel_s];
            tgt_r      <= sel_s ? TGT1 : TGT0;
            step_cnt_r <= 4'd0;
            err_r      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!hit_s) begin
            step_cnt_r <= step_cnt_r + 4'd1;
            if (limit_s) begin
              err_r <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          ptr_r <= ~owner_r;
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state and job context
  always_comb begin
    M    = 1'b0;
    STEP = 1'b0;
    GNT  = 2'b00;
    ACK  = 2'b00;
    ERR  = 1'b0;
    BUSY = (state_r != ST_IDLE);
    case (state_r)
      ST_RUN: begin
        M    = mode_r;
        STEP = ~hit_s;
        GNT  = owner_oh_s;
      end
      ST_FIN: begin
        GNT = owner_oh_s;
        ACK = owner_oh_s;
        ERR = err_r;
      end
      default: begin
        GNT = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_complex_counter_arbiter.sv
// Directed bench for complex_counter_arbiter with a behavioural shared counter
// (binary in mode 0, Gray in mode 1, optionally stuck).
module tb_complex_counter_arbiter;

  logic       CLOCK;
  logic       nReset;
  logic [1:0] REQ;
  logic [1:0] MODE_IN;
  logic [2:0] TGT0;
  logic [2:0] TGT1;
  logic [2:0] COUNT;
  logic       M;
  logic       STEP;
  logic [1:0] GNT;
  logic [1:0] ACK;
  logic       ERR;
  logic       BUSY;

  logic       load_en;
  logic [2:0] load_val;
  logic       stuck;

  int n_checks;
  int n_errors;

  complex_counter_arbiter #(.NSTEP_MAX(8)) dut (
    .CLOCK   (CLOCK),
    .nReset  (nReset),
    .REQ     (REQ),
    .MODE_IN (MODE_IN),
    .TGT0    (TGT0),
    .TGT1    (TGT1),
    .COUNT   (COUNT),
    .M       (M),
    .STEP    (STEP),
    .GNT     (GNT),
    .ACK     (ACK),
    .ERR     (ERR),
    .BUSY    (BUSY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [2:0] cnt_next(input logic [2:0] c, input logic mode);
    logic [2:0] b;
    if (!mode) begin
      cnt_next = c + 3'd1;
    end else begin
      b[2] = c[2];
      b[1] = b[2] ^ c[1];
      b[0] = b[1] ^ c[0];
      b = b + 3'd1;
      cnt_next = b ^ (b >> 1);
    end
  endfunction

  // Shared counter model
  always @(posedge CLOCK) begin
    if (load_en) COUNT <= load_val;
    else if (STEP && !stuck) COUNT <= cnt_next(COUNT, M);
  end

  function automatic logic [7:0] outv();
    return {GNT, ACK, ERR, STEP, M, BUSY};
  endfunction

  function automatic logic [7:0] vec(input logic [1:0] g, input logic [1:0] a, input logic e,
                                     input logic s, input logic m, input logic b);
    return {g, a, e, s, m, b};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLOCK);
  endtask

  task automatic load_count(input logic [2:0] v);
    load_en  = 1'b1;
    load_val = v;
    cyc();
    load_en  = 1'b0;
  endtask

  // Caller sets REQ at a negedge in IDLE; this follows the job through FIN.
  task automatic run_job(input string tag, input logic [1:0] own, input logic m,
                         input int exp_steps, input logic exp_err, input logic [2:0] exp_cnt);
    int steps;
    int n;
    cyc();
    chk({tag, "_run"}, outv(), vec(own, 2'b00, 1'b0, (exp_steps != 0), m, 1'b1));
    steps = 0;
    n = 0;
    while (ACK == 2'b00 && n < 30) begin
      if (STEP) steps++;
      cyc();
      n++;
    end
    chk({tag, "_ack_seen"}, 8'(ACK != 2'b00), 8'd1);
    chk({tag, "_steps"}, 8'(steps), 8'(exp_steps));
    chk({tag, "_run_cycles"}, 8'(n), 8'(exp_err ? exp_steps : exp_steps + 1));
    chk({tag, "_fin"}, outv(), vec(own, own, exp_err, 1'b0, 1'b0, 1'b1));
    chk({tag, "_count"}, 8'(COUNT), 8'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    nReset   = 1'b0;
    REQ      = 2'b00;
    MODE_IN  = 2'b00;
    TGT0     = 3'd0;
    TGT1     = 3'd0;
    stuck    = 1'b0;
    load_en  = 1'b1;
    load_val = 3'd0;
    #1;
    chk("reset_outputs", outv(), 8'h00);
    cyc();
    cyc();
    load_en = 1'b0;
    nReset  = 1'b1;
    chk("idle_after_reset", outv(), 8'h00);

    // Job 1: requester 0, binary, 0 -> 3
    REQ = 2'b01; MODE_IN = 2'b00; TGT0 = 3'd3;
    run_job("j1", 2'b01, 1'b0, 3, 1'b0, 3'd3);
    REQ = 2'b00;
    cyc();
    chk("j1_idle", outv(), 8'h00);

    // Job 2: requester 1, Gray, 0 -> 6 (0,1,3,2,6)
    load_count(3'd0);
    REQ = 2'b10; MODE_IN = 2'b10; TGT1 = 3'd6;
    run_job("j2", 2'b10, 1'b1, 4, 1'b0, 3'd6);
    REQ = 2'b00;
    cyc();
    chk("j2_idle", outv(), 8'h00);

    // Both requesting continuously: order 0,1,0,1 with one IDLE cycle between jobs
    load_count(3'd0);
    REQ = 2'b11; MODE_IN = 2'b00; TGT0 = 3'd1; TGT1 = 3'd2;
    run_job("rr_a", 2'b01, 1'b0, 1, 1'b0, 3'd1);
    cyc();
    chk("rr_gap_a", outv(), 8'h00);
    run_job("rr_b", 2'b10, 1'b0, 1, 1'b0, 3'd2);
    cyc();
    chk("rr_gap_b", outv(), 8'h00);
    run_job("rr_c", 2'b01, 1'b0, 7, 1'b0, 3'd1);
    cyc();
    chk("rr_gap_c", outv(), 8'h00);
    run_job("rr_d", 2'b10, 1'b0, 1, 1'b0, 3'd2);
    REQ = 2'b00;
    cyc();
    chk("rr_idle", outv(), 8'h00);

    // Target already equal to COUNT: one RUN cycle with STEP=0
    REQ = 2'b01; TGT0 = 3'd2;
    run_job("zero", 2'b01, 1'b0, 0, 1'b0, 3'd2);
    REQ = 2'b00;
    cyc();
    chk("zero_idle", outv(), 8'h00);

    // Stuck counter: step limit expires, ERR=1
    stuck = 1'b1;
    REQ = 2'b01; TGT0 = 3'd5;
    run_job("stuck", 2'b01, 1'b0, 8, 1'b1, 3'd2);
    REQ = 2'b00;
    stuck = 1'b0;
    cyc();
    chk("stuck_idle", outv(), 8'h00);

    // Reset mid-RUN (pointer currently favours requester 1)
    load_count(3'd0);
    REQ = 2'b11; TGT0 = 3'd7; TGT1 = 3'd7;
    cyc();
    chk("rst_pre_run", outv(), vec(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc();
    #2;
    nReset = 1'b0;
    #1;
    chk("rst_async_clear", outv(), 8'h00);
    cyc();
    chk("rst_hold_1", outv(), 8'h00);
    cyc();
    chk("rst_hold_2", outv(), 8'h00);
    chk("rst_count_frozen", 8'(COUNT), 8'd1);
    nReset = 1'b1;
    run_job("post_rst", 2'b01, 1'b0, 6, 1'b0, 3'd7);
    REQ = 2'b00;
    cyc();
    chk("post_rst_idle", outv(), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
